// File: rtl/muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : muldiv_unit
//  Purpose  : Iterative integer multiply / divide unit. One radix-2 step per
//             cycle: shift-add multiplication and restoring division, both on
//             operand magnitudes, with the sign applied to the final value.
//             Division by zero and signed overflow complete on the accept
//             edge.
//  Ports    : clk        - clock, rising edge active
//             rstn       - asynchronous active-low reset
//             in_valid   - request valid        in_ready  - unit idle
//             op         - 0 MUL 1 MULH 2 MULHSU 3 MULHU
//                          4 DIV 5 DIVU 6 REM  7 REMU
//             op1, op2   - multiplicand/dividend, multiplier/divisor
//             kill       - synchronous abort of any operation
//             out_valid  - result valid         out_ready - result consumed
//             result     - operation result (0 while out_valid is low)
//  Revision : 1.0 - initial release
// ============================================================================
module muldiv_unit #(
    parameter int XLEN  = 32,
    parameter int CNT_W = $clog2(XLEN) + 1
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] op1,
    input  logic [XLEN-1:0] op2,
    input  logic            kill,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] C_LAST    = CNT_W'(XLEN - 1);
    localparam logic [XLEN-1:0]  C_MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0]        state_q,  state_d;
    logic [CNT_W-1:0]  cnt_q,    cnt_d;
    logic [2:0]        op_q,     op_d;
    logic [2*XLEN-1:0] acc_q,    acc_d;    // {high half, low half}
    logic [XLEN-1:0]   mcand_q,  mcand_d;  // multiplicand or divisor magnitude
    logic              neg_q,    neg_d;    // negate product / quotient
    logic              negr_q,   negr_d;   // negate remainder
    logic [XLEN-1:0]   result_q, result_d;

    // ------------------------------------------------------------------
    // Request decode (applies to the inputs presented on accept)
    // ------------------------------------------------------------------
    logic            req_is_div;
    logic            req_s1, req_s2;
    logic            req_neg1, req_neg2;
    logic [XLEN-1:0] req_mag1, req_mag2;
    logic            req_div_zero, req_div_ovf;

    always_comb begin
        req_is_div   = op[2];
        req_s1       = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
        req_s2       = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
        req_neg1     = req_s1 && op1[XLEN-1];
        req_neg2     = req_s2 && op2[XLEN-1];
        // The magnitude of the most negative value is representable unsigned.
        req_mag1     = req_neg1 ? -op1 : op1;
        req_mag2     = req_neg2 ? -op2 : op2;
        req_div_zero = req_is_div && (op2 == '0);
        req_div_ovf  = ((op == 3'd4) || (op == 3'd6)) &&
                       (op1 == C_MOST_NEG) && (op2 == '1);
    end

    // ------------------------------------------------------------------
    // One iteration step
    // ------------------------------------------------------------------
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN-1:0]   div_part;
    logic              div_ge;
    logic [XLEN-1:0]   div_sub;
    logic [2*XLEN-1:0] div_next;
    logic [2*XLEN-1:0] step_next;

    always_comb begin
        // Shift-add: low half holds the remaining multiplier bits, the
        // product grows into the high half from the top.
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                   (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
        mul_next = {mul_sum, acc_q[XLEN-1:1]};

        // Restoring divide: partial remainder is {high half, next dividend
        // bit}. Its bit XLEN is the old high-half MSB; when set, the partial
        // remainder necessarily exceeds the divisor and the XLEN-bit modular
        // difference is exact because the true difference is below divisor.
        div_part = {acc_q[2*XLEN-2:XLEN], acc_q[XLEN-1]};
        div_ge   = acc_q[2*XLEN-1] || (div_part >= mcand_q);
        div_sub  = div_part - mcand_q;
        div_next = div_ge ? {div_sub,  acc_q[XLEN-2:0], 1'b1}
                          : {div_part, acc_q[XLEN-2:0], 1'b0};

        step_next = op_q[2] ? div_next : mul_next;
    end

    // ------------------------------------------------------------------
    // Sign correction of the value produced by the final step
    // ------------------------------------------------------------------
    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   mul_res;
    logic [XLEN-1:0]   quot_fix, rem_fix, div_res;
    logic [XLEN-1:0]   final_res;

    always_comb begin
        prod_fix  = neg_q ? -mul_next : mul_next;
        mul_res   = (op_q[1:0] == 2'd0) ? prod_fix[XLEN-1:0]
                                        : prod_fix[2*XLEN-1:XLEN];
        quot_fix  = neg_q  ? -div_next[XLEN-1:0]      : div_next[XLEN-1:0];
        rem_fix   = negr_q ? -div_next[2*XLEN-1:XLEN] : div_next[2*XLEN-1:XLEN];
        div_res   = op_q[1] ? rem_fix : quot_fix;
        final_res = op_q[2] ? div_res : mul_res;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        neg_d    = neg_q;
        negr_d   = negr_q;
        result_d = result_q;

        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    op_d   = op;
                    neg_d  = req_neg1 ^ req_neg2;
                    negr_d = req_neg1;
                    cnt_d  = '0;
                    if (req_div_zero) begin
                        // quotient all ones, remainder = dividend
                        result_d = op[1] ? op1 : '1;
                        state_d  = S_DONE;
                    end else if (req_div_ovf) begin
                        // quotient = dividend, remainder = 0
                        result_d = op[1] ? '0 : op1;
                        state_d  = S_DONE;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, req_is_div ? req_mag1 : req_mag2};
                        mcand_d = req_is_div ? req_mag2 : req_mag1;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = step_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == C_LAST) begin
                    result_d = final_res;
                    cnt_d    = '0;
                    state_d  = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    result_d = '0;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Abort has priority over accept, iteration and hand-off.
        if (kill) begin
            state_d  = S_IDLE;
            cnt_d    = '0;
            result_d = '0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            neg_q    <= 1'b0;
            negr_q   <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            neg_q    <= neg_d;
            negr_q   <= negr_d;
            result_q <= result_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign result    = out_valid ? result_q : '0;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_muldiv_unit
//  Purpose  : Directed self-checking bench for muldiv_unit (XLEN = 32).
//             A table of {op, operands, expected result, expected latency}
//             records plus hand-written sequences for back-pressure, kill
//             and asynchronous reset.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_muldiv_unit;

    localparam int XLEN = 32;

    logic            clk;
    logic            rstn;
    logic            in_valid;
    logic            in_ready;
    logic [2:0]      op;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic            kill;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] result;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op        (op),
        .op1       (op1),
        .op2       (op2),
        .kill      (kill),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [2:0] OP_MUL    = 3'd0;
    localparam logic [2:0] OP_MULH   = 3'd1;
    localparam logic [2:0] OP_MULHSU = 3'd2;
    localparam logic [2:0] OP_MULHU  = 3'd3;
    localparam logic [2:0] OP_DIV    = 3'd4;
    localparam logic [2:0] OP_DIVU   = 3'd5;
    localparam logic [2:0] OP_REM    = 3'd6;
    localparam logic [2:0] OP_REMU   = 3'd7;

    // lat = edges after the accept edge before out_valid is seen high;
    // special cases are valid right after the accept edge (lat 0).
    typedef struct {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        int          lat;
        string       name;
    } vec_t;

    vec_t vecs[$];
    int   n_cmp = 0;
    int   n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic add(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] e, input int l, input string n);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.exp = e; v.lat = l; v.name = n;
        vecs.push_back(v);
    endtask

    // Present a request and return just after its accept edge. Operands are
    // scrambled afterwards so any dependence on live inputs shows up.
    task automatic start_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                            input string nm);
        int w;
        w = 0;
        while (!in_ready && w < 100) begin
            @(posedge clk); #1; w++;
        end
        if (!in_ready) chk({nm, "_ready_timeout"}, 32'd0, 32'd1);
        op = o; op1 = a; op2 = b; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = ~o; op1 = ~a; op2 = ~b;
    endtask

    task automatic wait_done(output int lat);
        lat = 0;
        while (!out_valid && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic run_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e, input int l, input string nm);
        int lat;
        start_op(o, a, b, nm);
        if (l > 0) chk({nm, "_busy"}, {30'd0, out_valid, in_ready}, 32'd0);
        wait_done(lat);
        chk({nm, "_lat"}, lat, l);
        chk({nm, "_res"}, result, e);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({nm, "_release"}, {29'd0, out_valid, in_ready, |result}, 32'b010);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        logic seen;

        rstn = 1'b0; in_valid = 1'b0; op = '0; op1 = '0; op2 = '0;
        kill = 1'b0; out_ready = 1'b0;

        // ---------------- reset state ----------------
        #2;
        chk("reset_outputs", {29'd0, out_valid, in_ready, |result}, 32'b010);
        #10 rstn = 1'b1;
        @(posedge clk); #1;
        chk("post_reset_outputs", {29'd0, out_valid, in_ready, |result}, 32'b010);

        // ---------------- vector table ----------------
        add(OP_MUL,    32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFE, 32, "mul_ff_x2");
        add(OP_MULH,   32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32, "mulh_m1_x2");
        add(OP_MULHU,  32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32, "mulhu_ff_x2");
        add(OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780, 32, "mul_shift4");
        add(OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000, 32, "mulh_min_min");
        add(OP_MULHSU, 32'h80000000, 32'h80000000, 32'hC0000000, 32, "mulhsu_min");
        add(OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32, "mulhsu_m1");
        add(OP_DIV,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32, "div_m7_2");
        add(OP_REM,    32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32, "rem_m7_2");
        add(OP_DIV,    32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32, "div_7_m2");
        add(OP_REM,    32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32, "rem_7_m2");
        add(OP_DIVU,   32'h80000000, 32'h00000003, 32'h2AAAAAAA, 32, "divu_min_3");
        add(OP_REMU,   32'h80000000, 32'h00000003, 32'h00000002, 32, "remu_min_3");
        add(OP_DIVU,   32'hFFFFFFF9, 32'h00000002, 32'h7FFFFFFC, 32, "divu_big_2");
        add(OP_DIVU,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32, "divu_no_ovf");
        add(OP_DIV,    32'h12345678, 32'h00000000, 32'hFFFFFFFF, 0,  "div_by0");
        add(OP_DIVU,   32'h12345678, 32'h00000000, 32'hFFFFFFFF, 0,  "divu_by0");
        add(OP_REMU,   32'h12345678, 32'h00000000, 32'h12345678, 0,  "remu_by0");
        add(OP_REM,    32'h80000000, 32'h00000000, 32'h80000000, 0,  "rem_by0");
        add(OP_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, 0,  "div_ovf");
        add(OP_REM,    32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0,  "rem_ovf");
        add(OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32, "mulhu_ff_ff");

        foreach (vecs[i])
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].lat, vecs[i].name);

        // ---------------- back-pressure and back-to-back ----------------
        start_op(OP_MUL, 32'h00001234, 32'h00000010, "bp");
        wait_done(lat);
        chk("bp_lat", lat, 32);
        chk("bp_res", result, 32'h00012340);
        op = OP_MULHU; op1 = 32'hFFFFFFFF; op2 = 32'hFFFFFFFF; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_flags", {30'd0, out_valid, in_ready}, 32'b10);
            chk("bp_hold_res", result, 32'h00012340);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk("bp_release_idle", {30'd0, out_valid, in_ready}, 32'b01);
        @(posedge clk); #1;
        in_valid = 1'b0; op1 = '0; op2 = '0;
        chk("b2b_accepted", {31'd0, in_ready}, 32'd0);
        wait_done(lat);
        chk("b2b_lat", lat, 32);
        chk("b2b_res", result, 32'hFFFFFFFE);
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;

        // ---------------- kill ----------------
        start_op(OP_MUL, 32'h00000003, 32'h00000005, "kill");
        repeat (4) begin @(posedge clk); #1; end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_idle", {29'd0, out_valid, in_ready, |result}, 32'b010);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (out_valid) seen = 1'b1;
        end
        chk("kill_no_valid", {31'd0, seen}, 32'd0);
        run_op(OP_MUL, 32'h00000003, 32'h00000005, 32'h0000000F, 32, "after_kill");

        // kill beats accept in IDLE
        op = OP_DIV; op1 = 32'h5; op2 = 32'h0; in_valid = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; kill = 1'b0;
        chk("kill_vs_accept", {30'd0, out_valid, in_ready}, 32'b01);

        // kill in DONE discards the result
        start_op(OP_DIVU, 32'h5, 32'h0, "kill_done");
        chk("kill_done_valid", {31'd0, out_valid}, 32'd1);
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        chk("kill_done_idle", {29'd0, out_valid, in_ready, |result}, 32'b010);

        // ---------------- asynchronous reset mid-CALC ----------------
        start_op(OP_MUL, 32'h00000007, 32'h00000009, "arst");
        repeat (10) begin @(posedge clk); #1; end
        #2 rstn = 1'b0;
        #1;
        chk("arst_immediate", {29'd0, out_valid, in_ready, |result}, 32'b010);
        #2 rstn = 1'b1;
        @(posedge clk); #1;
        chk("arst_after", {29'd0, out_valid, in_ready, |result}, 32'b010);
        run_op(OP_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32, "arst_mulhu");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
